// File: rtl/signed_count_decoder_if.sv
// Sample/decode bundle between a signed up/down counter tap and its decoder.
// master drives the counter sample and steps; slave returns the decode results.
interface signed_count_decoder_if #(
   parameter int W     = 8,
   parameter int ERR_W = 8
);
   logic [W-1:0]     a;
   logic [W-1:0]     b;
   logic [W-1:0]     q;
   logic             q_valid;
   logic             dec_valid;
   logic             up_det;
   logic             dn_det;
   logic             hold_det;
   logic             err;
   logic             ovf;
   logic             locked;
   logic [ERR_W-1:0] err_count;

   modport master (
      output a, b, q, q_valid,
      input  dec_valid, up_det, dn_det, hold_det, err, ovf, locked, err_count
   );

   modport slave (
      input  a, b, q, q_valid,
      output dec_valid, up_det, dn_det, hold_det, err, ovf, locked, err_count
   );
endinterface

// File: rtl/signed_count_decoder.sv
// Monitor for a signed up/down counter: classifies each sample step, flags wrap,
// tracks lock and counts errors. DECODE_RESYNC_EN lets FAULT relock like TRACK.
module signed_count_decoder #(
   parameter int W      = 8,
   parameter int LOCK_N = 4,
   parameter int ERR_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   signed_count_decoder_if.slave bus
);
   localparam int RUN_W = $clog2(LOCK_N + 1);

   typedef enum logic [1:0] {PRIME, TRACK, LOCKED, FAULT} state_t;

   state_t           state, state_n;
   logic [RUN_W-1:0] run, run_n, run_inc;
   logic [W-1:0]     q_prev, delta, neg_b;
   logic             decode;
   logic             c_hold, c_up, c_dn, c_err, c_ovf;

   logic             dec_valid_r, up_r, dn_r, hold_r, err_r, ovf_r, locked_c;
   logic [ERR_W-1:0] err_count_r;

   assign delta  = bus.q - q_prev;
   assign neg_b  = '0 - bus.b;
   assign decode = bus.q_valid && (state != PRIME);

   // Priority hold > up > dn, so a == -b resolves as an up step.
   always_comb begin
      c_hold = (delta == '0);
      c_up   = !c_hold && (delta == bus.a);
      c_dn   = !c_hold && !c_up && (delta == neg_b);
      c_err  = !c_hold && !c_up && !c_dn;
      c_ovf  = 1'b0;
      if (c_up)
         c_ovf = (q_prev[W-1] == bus.a[W-1]) && (bus.q[W-1] != q_prev[W-1]);
      else if (c_dn)
         c_ovf = (q_prev[W-1] != bus.b[W-1]) && (bus.q[W-1] != q_prev[W-1]);
   end

   assign run_inc = (run == RUN_W'(LOCK_N)) ? run : run + 1'b1;

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= PRIME;
         run   <= '0;
      end else begin
         state <= state_n;
         run   <= run_n;
      end
   end

   // FSM: next state
   always_comb begin
      state_n = state;
      run_n   = run;
      case (state)
         PRIME: if (bus.q_valid) state_n = TRACK;
`ifdef DECODE_RESYNC_EN
         TRACK, FAULT: if (decode) begin
`else
         TRACK: if (decode) begin
`endif
            if (c_err) begin
               run_n = '0;
            end else begin
               run_n = run_inc;
               if (run_inc == RUN_W'(LOCK_N)) state_n = LOCKED;
            end
         end
         LOCKED: if (decode && c_err) begin
            state_n = FAULT;
            run_n   = '0;
         end
         default: ;
      endcase
   end

   // FSM: outputs
   always_comb locked_c = (state == LOCKED);

   always_ff @(posedge clk) begin
      if (rst) begin
         q_prev      <= '0;
         dec_valid_r <= 1'b0;
         up_r        <= 1'b0;
         dn_r        <= 1'b0;
         hold_r      <= 1'b0;
         err_r       <= 1'b0;
         ovf_r       <= 1'b0;
         err_count_r <= '0;
      end else begin
         dec_valid_r <= decode;
         up_r        <= decode && c_up;
         dn_r        <= decode && c_dn;
         hold_r      <= decode && c_hold;
         err_r       <= decode && c_err;
         ovf_r       <= decode && c_ovf;
         if (bus.q_valid) q_prev <= bus.q;
         if (decode && c_err && (err_count_r != '1)) err_count_r <= err_count_r + 1'b1;
      end
   end

   assign bus.dec_valid = dec_valid_r;
   assign bus.up_det    = up_r;
   assign bus.dn_det    = dn_r;
   assign bus.hold_det  = hold_r;
   assign bus.err       = err_r;
   assign bus.ovf       = ovf_r;
   assign bus.locked    = locked_c;
   assign bus.err_count = err_count_r;
endmodule

// File: tb/tb_signed_count_decoder.sv
// Directed vector bench for signed_count_decoder; expectations depend on
// whether DECODE_RESYNC_EN is defined.
module tb_signed_count_decoder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst2 = 1'b1;
   always #5 clk = ~clk;

   signed_count_decoder_if #(.W(8), .ERR_W(8)) bus ();
   signed_count_decoder_if #(.W(8), .ERR_W(2)) bus2 ();

   signed_count_decoder #(.W(8), .LOCK_N(4), .ERR_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
   signed_count_decoder #(.W(8), .LOCK_N(4), .ERR_W(2)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));

`ifdef DECODE_RESYNC_EN
   localparam bit RESYNC = 1'b1;
`else
   localparam bit RESYNC = 1'b0;
`endif

   // flags order: dec_valid, up, dn, hold, err, ovf, locked
   localparam logic [6:0] F0 = 7'b0000000;
   localparam logic [6:0] UP = 7'b1100000;
   localparam logic [6:0] DN = 7'b1010000;
   localparam logic [6:0] HD = 7'b1001000;
   localparam logic [6:0] ER = 7'b1000100;
   localparam logic [6:0] OV = 7'b0000010;
   localparam logic [6:0] LK = 7'b0000001;

   typedef struct {
      logic       rst;
      logic       qv;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] q;
      logic [6:0] flags;
      logic [7:0] ec;
   } vec_t;

   vec_t vecs[$];
   int   tests = 0;
   int   fails = 0;

   function automatic vec_t mk(logic r, logic qv, logic [7:0] a, logic [7:0] b, logic [7:0] q,
                               logic [6:0] f, logic [7:0] ec);
      vec_t v;
      v.rst = r; v.qv = qv; v.a = a; v.b = b; v.q = q; v.flags = f; v.ec = ec;
      return v;
   endfunction

   task automatic check(string name, int idx, logic [31:0] got, logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, got, exp);
      end
   endtask

   function automatic logic [6:0] flags_now();
      return {bus.dec_valid, bus.up_det, bus.dn_det, bus.hold_det, bus.err, bus.ovf, bus.locked};
   endfunction

   initial begin
      bus.q_valid = 1'b0; bus.a = '0; bus.b = '0; bus.q = '0;
      bus2.q_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.q = '0;

      // reset and up stream
      vecs.push_back(mk(1, 0, 8'd0,   8'd0,   8'd0,   F0, 0));
      vecs.push_back(mk(0, 1, 8'd53,  8'd13,  8'd0,   F0, 0));
      vecs.push_back(mk(0, 1, 8'd53,  8'd13,  8'd53,  UP, 0));
      vecs.push_back(mk(0, 1, 8'd53,  8'd13,  8'd106, UP, 0));
      // down steps with negative a
      vecs.push_back(mk(1, 0, 8'd0,   8'd0,   8'd0,   F0, 0));
      vecs.push_back(mk(0, 1, 8'hEF,  8'd37,  8'd0,   F0, 0));
      vecs.push_back(mk(0, 1, 8'hEF,  8'd37,  8'hDB,  DN, 0));
      vecs.push_back(mk(0, 1, 8'hEF,  8'd37,  8'hB6,  DN, 0));
      // overflow, up and down
      vecs.push_back(mk(1, 0, 8'd0,   8'd0,   8'd0,   F0, 0));
      vecs.push_back(mk(0, 1, 8'd53,  8'd13,  8'd106, F0, 0));
      vecs.push_back(mk(0, 1, 8'd53,  8'd13,  8'h9F,  UP | OV, 0));
      vecs.push_back(mk(1, 0, 8'd0,   8'd0,   8'd0,   F0, 0));
      vecs.push_back(mk(0, 1, 8'hD1,  8'hD5,  8'd100, F0, 0));
      vecs.push_back(mk(0, 1, 8'hD1,  8'hD5,  8'h8F,  DN | OV, 0));
      // gap then hold, then a == -b resolves as up
      vecs.push_back(mk(1, 0, 8'd0,   8'd0,   8'd0,   F0, 0));
      vecs.push_back(mk(0, 1, 8'd53,  8'd13,  8'd53,  F0, 0));
      vecs.push_back(mk(0, 0, 8'd53,  8'd13,  8'd7,   F0, 0));
      vecs.push_back(mk(0, 0, 8'd53,  8'd13,  8'd9,   F0, 0));
      vecs.push_back(mk(0, 0, 8'd53,  8'd13,  8'd11,  F0, 0));
      vecs.push_back(mk(0, 1, 8'd53,  8'd13,  8'd53,  HD, 0));
      vecs.push_back(mk(0, 1, 8'd5,   8'hFB,  8'd58,  UP, 0));
      // lock, fault, holds after fault
      vecs.push_back(mk(1, 0, 8'd0,   8'd0,   8'd0,   F0, 0));
      vecs.push_back(mk(0, 1, 8'd29,  8'hEF,  8'd0,   F0, 0));
      vecs.push_back(mk(0, 1, 8'd29,  8'hEF,  8'd29,  UP, 0));
      vecs.push_back(mk(0, 1, 8'd29,  8'hEF,  8'd58,  UP, 0));
      vecs.push_back(mk(0, 1, 8'd29,  8'hEF,  8'd87,  UP, 0));
      vecs.push_back(mk(0, 1, 8'd29,  8'hEF,  8'd116, UP | LK, 0));
      vecs.push_back(mk(0, 1, 8'd29,  8'hEF,  8'd117, ER, 1));
      vecs.push_back(mk(0, 1, 8'd29,  8'hEF,  8'd117, HD, 1));
      vecs.push_back(mk(0, 1, 8'd29,  8'hEF,  8'd117, HD, 1));
      vecs.push_back(mk(0, 1, 8'd29,  8'hEF,  8'd117, HD, 1));
      vecs.push_back(mk(0, 1, 8'd29,  8'hEF,  8'd117, HD | (RESYNC ? LK : F0), 1));
      vecs.push_back(mk(0, 1, 8'd29,  8'hEF,  8'd0,   ER, 2));
      // reset while locked; the next sample only primes
      vecs.push_back(mk(1, 0, 8'd0,   8'd0,   8'd0,   F0, 0));
      vecs.push_back(mk(0, 1, 8'd29,  8'hEF,  8'd0,   F0, 0));
      vecs.push_back(mk(0, 1, 8'd29,  8'hEF,  8'd29,  UP, 0));
      vecs.push_back(mk(0, 1, 8'd29,  8'hEF,  8'd58,  UP, 0));
      vecs.push_back(mk(0, 1, 8'd29,  8'hEF,  8'd87,  UP, 0));
      vecs.push_back(mk(0, 1, 8'd29,  8'hEF,  8'd116, UP | LK, 0));
      vecs.push_back(mk(1, 1, 8'd29,  8'hEF,  8'd145, F0, 0));
      vecs.push_back(mk(0, 1, 8'd29,  8'hEF,  8'd50,  F0, 0));
      vecs.push_back(mk(0, 1, 8'd29,  8'hEF,  8'd79,  UP, 0));
      // err during TRACK restarts the run
      vecs.push_back(mk(1, 0, 8'd0,   8'd0,   8'd0,   F0, 0));
      vecs.push_back(mk(0, 1, 8'd29,  8'hEF,  8'd0,   F0, 0));
      vecs.push_back(mk(0, 1, 8'd29,  8'hEF,  8'd29,  UP, 0));
      vecs.push_back(mk(0, 1, 8'd29,  8'hEF,  8'd58,  UP, 0));
      vecs.push_back(mk(0, 1, 8'd29,  8'hEF,  8'd60,  ER, 1));
      vecs.push_back(mk(0, 1, 8'd29,  8'hEF,  8'd77,  DN, 1));
      vecs.push_back(mk(0, 1, 8'd29,  8'hEF,  8'd94,  DN, 1));
      vecs.push_back(mk(0, 1, 8'd29,  8'hEF,  8'd111, DN, 1));
      vecs.push_back(mk(0, 1, 8'd29,  8'hEF,  8'd111, HD | LK, 1));
      vecs.push_back(mk(0, 0, 8'd29,  8'hEF,  8'd200, LK, 1));

      repeat (2) @(posedge clk);
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rst         = vecs[i].rst;
         bus.q_valid = vecs[i].qv;
         bus.a       = vecs[i].a;
         bus.b       = vecs[i].b;
         bus.q       = vecs[i].q;
         @(posedge clk);
         #1;
         check("flags", i, 32'(flags_now()), 32'(vecs[i].flags));
         check("err_count", i, 32'(bus.err_count), 32'(vecs[i].ec));
      end

      // err_count saturation on a 2-bit counter
      @(negedge clk);
      rst2 = 1'b1;
      @(posedge clk); #1;
      check("sat_reset", 0, 32'(bus2.err_count), 32'd0);
      @(negedge clk);
      rst2 = 1'b0; bus2.q_valid = 1'b1; bus2.a = 8'd1; bus2.b = 8'd1; bus2.q = 8'd0;
      @(posedge clk); #1;
      check("sat_prime", 0, 32'(bus2.dec_valid), 32'd0);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         bus2.q = 8'(10 * k);
         @(posedge clk); #1;
         check("sat_err", k, 32'(bus2.err), 32'd1);
         check("sat_count", k, 32'(bus2.err_count), (k < 3) ? 32'(k) : 32'd3);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
